ai_cache_sa: RTL

Parametrised N-way set-associative successor to the direct-mapped AI accelerator cache. It accepts single-beat read/write requests over a valid/ready handshake and returns one registered response per accepted request. Replacement is true LRU per set, and a multi-cycle flush sequencer invalidates the array. It sits between the accelerator load/store unit and local buffer storage; misses are reported, not refilled.

---
 rtl/ai_cache_sa_pkg.sv | 24 ++
 rtl/ai_cache_sa_if.sv | 37 +++
 rtl/ai_cache_sa_lru.sv | 56 +++++
 rtl/ai_cache_sa.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ai_cache_sa_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : ai_cache_pkg                                                 |
// | Description : Shared types and helpers for the set-associative AI cache.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package ai_cache_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } cache_state_e;

    localparam int STAT_WIDTH = 32;

    // Index/way widths must stay at least one bit so degenerate sizes still elaborate
    function automatic int clog2_safe(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ai_cache_sa_if.sv
// +----------------------------------------------------------------------------+
// | Module      : ai_cache_sa_if                                               |
// | Description : Request/response/flush bundle between the LSU and the cache. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface ai_cache_sa_if
    import ai_cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  flush;
    logic                  resp_valid;
    logic                  resp_hit;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, flush,
        input  req_ready, resp_valid, resp_hit, resp_rdata, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, flush,
        output req_ready, resp_valid, resp_hit, resp_rdata, busy
    );

endinterface

`default_nettype wire

// File: rtl/ai_cache_sa_lru.sv
// +----------------------------------------------------------------------------+
// | Module      : ai_cache_lru                                                 |
// | Description : Combinational true-LRU age update and victim select, 1 set.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module ai_cache_lru
    import ai_cache_pkg::*;
#(
    parameter  int WAYS  = 4,
    localparam int WAY_W = clog2_safe(WAYS)
) (
    input  logic [WAYS-1:0][WAY_W-1:0] ages_in,
    input  logic [WAY_W-1:0]           touch_way,
    output logic [WAYS-1:0][WAY_W-1:0] ages_out,
    output logic [WAY_W-1:0]           victim_way
);

    generate
        if (WAYS == 1) begin : g_direct
            logic w_unused;
            assign w_unused   = ^{ages_in, touch_way};
            assign ages_out   = '0;
            assign victim_way = '0;
        end else begin : g_lru
            logic [WAY_W-1:0] w_old_age;

            assign w_old_age = ages_in[touch_way];

            // Touched way becomes MRU; only younger ways age, keeping a permutation
            always_comb begin
                ages_out = ages_in;
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == touch_way) begin
                        ages_out[w] = '0;
                    end else if (ages_in[w] < w_old_age) begin
                        ages_out[w] = ages_in[w] + 1'b1;
                    end
                end
            end

            always_comb begin
                victim_way = '0;
                for (int w = 0; w < WAYS; w++) begin
                    if (ages_in[w] == WAY_W'(WAYS - 1)) begin
                        victim_way = WAY_W'(w);
                    end
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/ai_cache_sa.sv
// +----------------------------------------------------------------------------+
// | Module      : ai_cache_sa                                                  |
// | Description : N-way set-associative AI cache, true LRU, flush sequencer.   |
// |               Define AI_CACHE_STATS_EN to add hit/miss counter ports.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module ai_cache_sa
    import ai_cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128,
    parameter int SETS       = 256,
    parameter int WAYS       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    ai_cache_sa_if.slave          bus
`ifdef AI_CACHE_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] hit_count,
    output logic [STAT_WIDTH-1:0] miss_count
`endif
);

    localparam int IDX_W = clog2_safe(SETS);
    localparam int TAG_W = ADDR_WIDTH - IDX_W;
    localparam int WAY_W = clog2_safe(WAYS);

    typedef logic [WAYS-1:0][WAY_W-1:0] age_vec_t;

    // Line storage in flops so reset and flush can clear valid bits in bulk
    logic [WAYS-1:0]       r_valid [SETS];
    logic [TAG_W-1:0]      r_tag   [SETS][WAYS];
    logic [DATA_WIDTH-1:0] r_data  [SETS][WAYS];
    age_vec_t              r_age   [SETS];

    cache_state_e          r_state;
    cache_state_e          w_state_nxt;
    logic [IDX_W-1:0]      r_flush_ptr;

    logic                  r_resp_valid;
    logic                  r_resp_hit;
    logic [DATA_WIDTH-1:0] r_resp_rdata;

    logic [IDX_W-1:0]      w_index;
    logic [TAG_W-1:0]      w_tag;
    logic                  w_req_ready;
    logic                  w_accept;
    logic [WAYS-1:0]       w_match;
    logic                  w_hit;
    logic [WAY_W-1:0]      w_hit_way;
    logic                  w_free_found;
    logic [WAY_W-1:0]      w_free_way;
    logic [WAY_W-1:0]      w_victim_way;
    logic [WAY_W-1:0]      w_touch_way;
    age_vec_t              w_age_new;
    logic                  w_update;

    assign w_index = bus.req_addr[IDX_W-1:0];
    assign w_tag   = bus.req_addr[ADDR_WIDTH-1:IDX_W];

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_flush_ptr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_ptr <= (r_state == IDLE) ? '0 : r_flush_ptr + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = !bus.flush && reset;
                if (bus.flush) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (r_flush_ptr == IDX_W'(SETS - 1)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_accept = bus.req_valid && w_req_ready;

    // ---------------- Lookup ----------------
    always_comb begin
        w_match      = '0;
        w_hit_way    = '0;
        w_free_found = 1'b0;
        w_free_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_index][w] && (r_tag[w_index][w] == w_tag)) begin
                w_match[w] = 1'b1;
                w_hit_way  = WAY_W'(w);
            end
        end
        // Descending scan leaves the lowest-numbered invalid way selected
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_index][w]) begin
                w_free_found = 1'b1;
                w_free_way   = WAY_W'(w);
            end
        end
    end

    assign w_hit       = |w_match;
    assign w_touch_way = w_hit        ? w_hit_way :
                         w_free_found ? w_free_way : w_victim_way;
    assign w_update    = w_accept && (w_hit || bus.req_write);

    ai_cache_lru #(
        .WAYS (WAYS)
    ) u_lru (
        .ages_in    (r_age[w_index]),
        .touch_way  (w_touch_way),
        .ages_out   (w_age_new),
        .victim_way (w_victim_way)
    );

    // ---------------- Array state ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_age[s][w] <= WAY_W'(w);
                end
            end
        end else if (r_state == FLUSH) begin
            r_valid[r_flush_ptr] <= '0;
            for (int w = 0; w < WAYS; w++) begin
                r_age[r_flush_ptr][w] <= WAY_W'(w);
            end
        end else if (w_update) begin
            r_age[w_index] <= w_age_new;
            if (bus.req_write && !w_hit) begin
                r_valid[w_index][w_touch_way] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_update && bus.req_write) begin
            r_data[w_index][w_touch_way] <= bus.req_wdata;
            if (!w_hit) begin
                r_tag[w_index][w_touch_way] <= w_tag;
            end
        end
    end

    // ---------------- Response ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_resp_valid <= w_accept;
            r_resp_hit   <= w_accept && w_hit;
            r_resp_rdata <= (w_accept && w_hit && !bus.req_write) ?
                            r_data[w_index][w_hit_way] : '0;
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_hit   = r_resp_hit;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.busy       = (r_state == FLUSH);

`ifdef AI_CACHE_STATS_EN
    logic [STAT_WIDTH-1:0] r_hit_count;
    logic [STAT_WIDTH-1:0] r_miss_count;

    // Saturating counters; flush leaves them untouched
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (w_accept) begin
            if (w_hit) begin
                if (r_hit_count != '1) begin
                    r_hit_count <= r_hit_count + 1'b1;
                end
            end else begin
                if (r_miss_count != '1) begin
                    r_miss_count <= r_miss_count + 1'b1;
                end
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

`default_nettype wire
